// File: rtl/seven_segment_pkg.sv
// seven_segment_pkg: shared hex font and segment bit positions
// for the multiplexed seven-segment scanner.
package seven_segment_pkg;

  localparam int SEG_DP = 7;
  localparam int SEG_A  = 6;
  localparam int SEG_B  = 5;
  localparam int SEG_C  = 4;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 2;
  localparam int SEG_F  = 1;
  localparam int SEG_G  = 0;

  // active-high, bit 6 = a ... bit 0 = g; b and d lowercase
  localparam logic [6:0] FONT [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79,
    7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F,
    7'h4E, 7'h3D, 7'h4F, 7'h47
  };

endpackage

// File: rtl/seg_font_decode.sv
// seg_font_decode: nibble to active-high abcdefg pattern.
// Purely combinational; the parent applies output polarity.
module seg_font_decode
  import seven_segment_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = FONT[nibble];

endmodule

// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner: time-multiplexed hex display driver with
// frame-latched data, leading-zero suppression and PWM brightness.
module seven_segment_scanner
  import seven_segment_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int DIV            = 1024,
  parameter int BRIGHT_W       = 4,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blank,
  input  logic                  lz_en,
  input  logic [BRIGHT_W-1:0]   brightness,
  output logic [7:0]            segments,
  output logic [DIGITS-1:0]     anodes,
  output logic                  frame_done
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CW-1:0] CMAX = CW'(DIV - 1);
  localparam logic [IW-1:0] IMAX = IW'(DIGITS - 1);
  localparam logic [CW-1:0] STEP = CW'(DIV / (2 ** BRIGHT_W));

  localparam logic [7:0] SEG_OFF =
    (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] AN_OFF =
    (AN_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : '0;

  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [4*DIGITS-1:0]   value_sh;
  logic [DIGITS-1:0]     dp_sh;
  logic [DIGITS-1:0]     blank_sh;
  logic                  lz_sh;
  logic                  loaded;

  logic                  slot_end;
  logic                  wrap;

  assign slot_end = (cnt == CMAX);
  assign wrap     = slot_end && (idx == IMAX);

  // scan timing and frame-latched shadows
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      idx      <= '0;
      value_sh <= '0;
      dp_sh    <= '0;
      blank_sh <= '0;
      lz_sh    <= 1'b0;
      loaded   <= 1'b0;
    end else begin
      cnt <= slot_end ? '0 : cnt + CW'(1);
      if (slot_end) begin
        idx <= (idx == IMAX) ? '0 : idx + IW'(1);
      end
      if (wrap) begin
        value_sh <= value;
        dp_sh    <= dp;
        blank_sh <= blank;
        lz_sh    <= lz_en;
        loaded   <= 1'b1;
      end
    end
  end

  logic [DIGITS-1:0] supp;
  logic              zrun;

  // a digit is suppressed while every digit above it is a bare zero
  always_comb begin
    supp = '0;
    zrun = lz_sh;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zrun = zrun
        && (value_sh[4*i +: 4] == 4'h0)
        && !dp_sh[i];
      supp[i] = zrun;
    end
  end

  logic [3:0]        nib;
  logic              cur_dp;
  logic              cur_off;
  logic [DIGITS-1:0] onehot;

  always_comb begin
    nib     = 4'h0;
    cur_dp  = 1'b0;
    cur_off = 1'b0;
    onehot  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (int'(idx) == i) begin
        nib       = value_sh[4*i +: 4];
        cur_dp    = dp_sh[i];
        cur_off   = blank_sh[i] | supp[i];
        onehot[i] = 1'b1;
      end
    end
  end

  logic [6:0] font;

  seg_font_decode u_font (
    .nibble (nib),
    .seg    (font)
  );

  logic [CW-1:0] duty;
  logic          lit;
  logic          en;
  logic [7:0]    seg_hi;

  assign duty = CW'(brightness) * STEP;
  assign lit  = loaded && !cur_off;
  // cnt == 0 is the dark guard between digits
  assign en   = lit && (cnt != '0) && (cnt <= duty);

  always_comb begin
    seg_hi = 8'h00;
    if (lit) begin
      seg_hi[SEG_DP]      = cur_dp;
      seg_hi[SEG_A:SEG_G] = font;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      segments   <= SEG_OFF;
      anodes     <= AN_OFF;
      frame_done <= 1'b0;
    end else begin
      segments   <= seg_hi ^ SEG_OFF;
      anodes     <= (en ? onehot : '0) ^ AN_OFF;
      frame_done <= wrap;
    end
  end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// tb_seven_segment_scanner: table-driven scan checks with a
// per-cycle scoreboard plus tear-free and mid-slot reset sequences.
module tb_seven_segment_scanner;

  localparam int DIGITS = 4;
  localparam int DIV    = 16;
  localparam int FRAME  = DIGITS * DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  blank;
  logic        lz_en;
  logic [1:0]  brightness;
  logic [7:0]  segments;
  logic [3:0]  anodes;
  logic        frame_done;

  always #5 clk = ~clk;

  seven_segment_scanner #(
    .DIGITS         (DIGITS),
    .DIV            (DIV),
    .BRIGHT_W       (2),
    .SEG_ACTIVE_LOW (1),
    .AN_ACTIVE_LOW  (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value      (value),
    .dp         (dp),
    .blank      (blank),
    .lz_en      (lz_en),
    .brightness (brightness),
    .segments   (segments),
    .anodes     (anodes),
    .frame_done (frame_done)
  );

  // code[i]: active-low pattern of digit i, 8'hFF = digit dark
  typedef struct {
    logic [15:0]     value;
    logic [3:0]      dp;
    logic [3:0]      blank;
    logic            lz;
    logic [1:0]      bright;
    logic [3:0][7:0] code;
  } vec_t;

  typedef struct {
    logic [7:0] seg;
    logic [3:0] an;
    logic       fd;
  } exp_t;

  vec_t            V [10];
  exp_t            q [$];
  logic [3:0][7:0] cur_code;
  logic [3:0][7:0] sh;
  int              k = 0;
  bit              ld = 1'b0;
  int              n_assert = 0;
  int              n_fail = 0;

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] want);
    n_assert++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %02h want %02h at %0t",
               nm, act, want, $time);
    end
  endtask

  task automatic tmo(input string nm);
    n_assert++;
    n_fail++;
    $display("FAIL %s: timed out at %0t", nm, $time);
  endtask

  task automatic apply(input vec_t v);
    value      = v.value;
    dp         = v.dp;
    blank      = v.blank;
    lz_en      = v.lz;
    brightness = v.bright;
    cur_code   = v.code;
  endtask

  // scoreboard: predict at the edge, compare on the next falling edge
  initial begin : mon
    exp_t e;
    int   c, d;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        k  = 0;
        ld = 1'b0;
        q.delete();
      end else begin
        k++;
        c = (k - 1) % DIV;
        d = ((k - 1) / DIV) % DIGITS;
        e.seg = ld ? sh[d] : 8'hFF;
        e.an  = 4'hF;
        if (ld && sh[d] != 8'hFF && c >= 1
            && c <= int'(brightness) * (DIV / 4))
          e.an[d] = 1'b0;
        e.fd = (k % FRAME == 0);
        q.push_back(e);
        if (k % FRAME == 0) begin
          sh = cur_code;
          ld = 1'b1;
        end
      end
      @(negedge clk);
      if (rst_n && q.size() > 0) begin
        e = q.pop_front();
        chk("segments", segments, e.seg);
        chk("anodes", {4'h0, anodes}, {4'h0, e.an});
        chk("frame_done", {7'h0, frame_done}, {7'h0, e.fd});
      end
    end
  end

  initial begin : stim
    int n;
    V[0] = '{16'h12AF, 4'h0, 4'h0, 1'b0, 2'd3,
             {8'hCF, 8'h92, 8'h88, 8'hB8}};
    V[1] = '{16'h0040, 4'h0, 4'h0, 1'b1, 2'd3,
             {8'hFF, 8'hFF, 8'hCC, 8'h81}};
    V[2] = '{16'h0040, 4'h8, 4'h0, 1'b1, 2'd2,
             {8'h01, 8'h81, 8'hCC, 8'h81}};
    V[3] = '{16'h0040, 4'h0, 4'h0, 1'b0, 2'd1,
             {8'h81, 8'h81, 8'hCC, 8'h81}};
    V[4] = '{16'h1234, 4'h0, 4'h0, 1'b0, 2'd0,
             {8'hCF, 8'h92, 8'h86, 8'hCC}};
    V[5] = '{16'h1234, 4'h0, 4'hF, 1'b0, 2'd3,
             {8'hFF, 8'hFF, 8'hFF, 8'hFF}};
    V[6] = '{16'h0000, 4'h2, 4'h0, 1'b1, 2'd3,
             {8'hFF, 8'hFF, 8'h01, 8'h81}};
    V[7] = '{16'h8E0C, 4'h0, 4'h4, 1'b0, 2'd2,
             {8'h80, 8'hFF, 8'h81, 8'hB1}};
    V[8] = '{16'h9D6B, 4'h5, 4'h0, 1'b0, 2'd3,
             {8'h84, 8'h42, 8'hA0, 8'h60}};
    V[9] = '{16'h0305, 4'h0, 4'h0, 1'b1, 2'd3,
             {8'hFF, 8'h86, 8'h81, 8'hA4}};

    apply(V[0]);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_segments", segments, 8'hFF);
    chk("rst_anodes", {4'h0, anodes}, 8'h0F);
    chk("rst_frame_done", {7'h0, frame_done}, 8'h00);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      apply(V[i]);
      repeat (2 * FRAME) @(negedge clk);
    end

    // change data mid-frame; old frame must finish untouched
    apply(V[8]);
    repeat (2 * FRAME) @(negedge clk);
    n = 0;
    while ((k % FRAME) != 20 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if ((k % FRAME) != 20) tmo("phase20");
    apply(V[0]);
    n = 0;
    while (!frame_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!frame_done) tmo("tear_fd");
    chk("tear_old", segments, 8'h84);
    @(negedge clk);
    chk("tear_new", segments, 8'hB8);
    repeat (FRAME) @(negedge clk);

    // asynchronous reset in the middle of digit 2, cnt 7
    n = 0;
    while ((k % FRAME) != 39 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if ((k % FRAME) != 39) tmo("phase39");
    #1 rst_n = 1'b0;
    #1;
    chk("async_segments", segments, 8'hFF);
    chk("async_anodes", {4'h0, anodes}, 8'h0F);
    chk("async_frame_done", {7'h0, frame_done}, 8'h00);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 100);
    chk("first_fd_delay", 8'(n), 8'd64);
    repeat (FRAME + 4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
